// File: rtl/segre_store_buffer_q.sv
// -----------------------------------------------------------------------------
// segre_store_buffer_q
//
// Purpose:
//   Store buffer for the memory stage. Committed stores are queued in program
//   order in a circular buffer of NUM_ELEMS entries. Younger loads look the
//   buffer up combinationally:
//     - exact match (same address and type)  -> hit, data forwarded
//     - same word but a different shape      -> trouble
//     - no entry in the same word            -> miss
//   The oldest entry drains to the data cache through a valid/ready
//   handshake. Draining happens either opportunistically (cache idle) or
//   unconditionally while a fence (flush-all) is in progress. A store with the
//   same address and type as the youngest entry can be merged into it.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_store_i           push a store (addr_i, data_i, memop_data_type_i)
//   addr_i                store or load address
//   data_i                store data, already byte-lane aligned
//   memop_data_type_i     BYTE=0, HALF=1, WORD=2
//   req_load_i            lookup request
//   flush_chance_i        cache idle, opportunistic drain allowed
//   flush_all_i           fence request (single-cycle pulse)
//   drain_ready_i         cache accepts the head entry
//   hit_o/miss_o/trouble_o  lookup result (all 0 without req_load_i)
//   data_o                forwarded data on hit
//   drain_valid_o         head entry offered to the cache
//   addr_o, drain_data_o, memop_data_type_o   head entry fields
//   full_o, empty_o       occupancy flags from the registered count
//   flush_done_o          one-cycle pulse when a fence completes
// -----------------------------------------------------------------------------
module segre_store_buffer_q #(
  parameter int unsigned NUM_ELEMS   = 4,
  parameter int unsigned ADDR_SIZE   = 32,
  parameter int unsigned WORD_SIZE   = 32,
  parameter bit          COALESCE_EN = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_store_i,
  input  logic [ADDR_SIZE-1:0] addr_i,
  input  logic [WORD_SIZE-1:0] data_i,
  input  logic [1:0]           memop_data_type_i,
  input  logic                 req_load_i,
  input  logic                 flush_chance_i,
  input  logic                 flush_all_i,
  input  logic                 drain_ready_i,
  output logic                 hit_o,
  output logic                 miss_o,
  output logic                 trouble_o,
  output logic [WORD_SIZE-1:0] data_o,
  output logic                 drain_valid_o,
  output logic [ADDR_SIZE-1:0] addr_o,
  output logic [WORD_SIZE-1:0] drain_data_o,
  output logic [1:0]           memop_data_type_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 flush_done_o
);

  localparam int unsigned PTR_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_ELEMS + 1);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_ELEMS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_ELEMS);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Pointers wrap explicitly so NUM_ELEMS need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? LAST_IDX : p - 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [NUM_ELEMS-1:0]   valid_q, valid_d;
  logic                   flush_done_q, flush_done_d;

  logic [ADDR_SIZE-1:0]   addr_q [NUM_ELEMS];
  logic [WORD_SIZE-1:0]   data_q [NUM_ELEMS];
  logic [1:0]             type_q [NUM_ELEMS];

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic             pop;
  logic             push;
  logic             coalesce;
  logic [PTR_W-1:0] youngest;
  logic [PTR_W-1:0] wr_idx;
  logic             wr_en;

  assign empty_o       = (count_q == '0);
  assign full_o        = (count_q == FULL_CNT);
  assign drain_valid_o = !empty_o && (flush_chance_i || (state_q == ST_FLUSH));
  assign pop           = drain_valid_o && drain_ready_i;
  assign youngest      = ptr_dec(tail_q);

  // Merging into the youngest entry is not allowed if that entry is leaving
  // this cycle; the store then falls back to a normal push.
  assign coalesce = COALESCE_EN && req_store_i && !empty_o
                 && (addr_q[youngest] == addr_i)
                 && (type_q[youngest] == memop_data_type_i)
                 && !((youngest == head_q) && pop);

  assign push   = req_store_i && !full_o && !coalesce;
  assign wr_en  = push || coalesce;
  assign wr_idx = coalesce ? youngest : tail_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    valid_d      = valid_q;
    state_d      = state_q;
    flush_done_d = 1'b0;

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = ptr_inc(head_q);
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = ptr_inc(tail_q);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    unique case (state_q)
      ST_IDLE: begin
        if (flush_all_i) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // A store arriving while empty extends the fence.
        if (empty_o && !push) begin
          state_d      = ST_IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      valid_q      <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      flush_done_q <= flush_done_d;
    end
  end

  // NOTE: the payload storage has no reset; valid bits and the empty gating
  // on the outputs make stale contents unobservable.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      addr_q[wr_idx] <= addr_i;
      data_q[wr_idx] <= data_i;
      type_q[wr_idx] <= memop_data_type_i;
    end
  end

  assign flush_done_o = flush_done_q;

  // ---------------------------------------------------------------------------
  // Drain outputs (head entry)
  // ---------------------------------------------------------------------------
  assign addr_o            = empty_o ? '0 : addr_q[head_q];
  assign drain_data_o      = empty_o ? '0 : data_q[head_q];
  assign memop_data_type_o = empty_o ? '0 : type_q[head_q];

  // ---------------------------------------------------------------------------
  // Load lookup: walk oldest to youngest so the last same-word match seen is
  // the youngest one, which is the entry that decides the result.
  // ---------------------------------------------------------------------------
  logic             match_found;
  logic             match_exact;
  logic [WORD_SIZE-1:0] match_data;
  logic [PTR_W-1:0] scan;

  // NOTE: combinational logic uses blocking assignments with every variable
  // defaulted first, so the loop reads its own updates and no latch is built.
  always_comb begin
    match_found = 1'b0;
    match_exact = 1'b0;
    match_data  = '0;
    scan        = head_q;
    for (int unsigned k = 0; k < NUM_ELEMS; k++) begin
      if (valid_q[scan] && (addr_q[scan][ADDR_SIZE-1:2] == addr_i[ADDR_SIZE-1:2])) begin
        match_found = 1'b1;
        match_exact = (addr_q[scan] == addr_i) && (type_q[scan] == memop_data_type_i);
        match_data  = data_q[scan];
      end
      scan = ptr_inc(scan);
    end
  end

  assign hit_o     = req_load_i && match_found && match_exact;
  assign trouble_o = req_load_i && match_found && !match_exact;
  assign miss_o    = req_load_i && !match_found;
  assign data_o    = hit_o ? match_data : '0;

endmodule

// File: tb/tb_segre_store_buffer_q.sv
// -----------------------------------------------------------------------------
// tb_segre_store_buffer_q
//
// Directed bench for segre_store_buffer_q. Two instances share every input:
// dut merges same-address stores, dut_nc does not. Inputs change 1 time unit
// after the rising edge and outputs are compared 2 units later, mid-cycle.
// -----------------------------------------------------------------------------
module tb_segre_store_buffer_q;

  localparam int unsigned N = 4;
  localparam logic [1:0] T_BYTE = 2'd0;
  localparam logic [1:0] T_HALF = 2'd1;
  localparam logic [1:0] T_WORD = 2'd2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_store_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [1:0]  memop_data_type_i;
  logic        req_load_i;
  logic        flush_chance_i;
  logic        flush_all_i;
  logic        drain_ready_i;

  logic        hit_o, miss_o, trouble_o, drain_valid_o, full_o, empty_o, flush_done_o;
  logic [31:0] data_o, addr_o, drain_data_o;
  logic [1:0]  memop_data_type_o;

  logic        nc_hit, nc_miss, nc_trouble, nc_drain_valid, nc_full, nc_empty, nc_flush_done;
  logic [31:0] nc_data, nc_addr, nc_drain_data;
  logic [1:0]  nc_type;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  segre_store_buffer_q #(.NUM_ELEMS(N), .ADDR_SIZE(32), .WORD_SIZE(32), .COALESCE_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_store_i(req_store_i), .addr_i(addr_i), .data_i(data_i),
    .memop_data_type_i(memop_data_type_i), .req_load_i(req_load_i),
    .flush_chance_i(flush_chance_i), .flush_all_i(flush_all_i), .drain_ready_i(drain_ready_i),
    .hit_o(hit_o), .miss_o(miss_o), .trouble_o(trouble_o), .data_o(data_o),
    .drain_valid_o(drain_valid_o), .addr_o(addr_o), .drain_data_o(drain_data_o),
    .memop_data_type_o(memop_data_type_o), .full_o(full_o), .empty_o(empty_o),
    .flush_done_o(flush_done_o)
  );

  segre_store_buffer_q #(.NUM_ELEMS(N), .ADDR_SIZE(32), .WORD_SIZE(32), .COALESCE_EN(1'b0)) dut_nc (
    .clk_i(clk), .rst_i(rst_i), .req_store_i(req_store_i), .addr_i(addr_i), .data_i(data_i),
    .memop_data_type_i(memop_data_type_i), .req_load_i(req_load_i),
    .flush_chance_i(flush_chance_i), .flush_all_i(flush_all_i), .drain_ready_i(drain_ready_i),
    .hit_o(nc_hit), .miss_o(nc_miss), .trouble_o(nc_trouble), .data_o(nc_data),
    .drain_valid_o(nc_drain_valid), .addr_o(nc_addr), .drain_data_o(nc_drain_data),
    .memop_data_type_o(nc_type), .full_o(nc_full), .empty_o(nc_empty),
    .flush_done_o(nc_flush_done)
  );

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no checking)
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    req_store_i       = 1'b0;
    addr_i            = '0;
    data_i            = '0;
    memop_data_type_i = '0;
    req_load_i        = 1'b0;
    flush_chance_i    = 1'b0;
    flush_all_i       = 1'b0;
    drain_ready_i     = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b1;
    cyc();
    cyc();
    rst_i = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
    req_store_i       = 1'b1;
    addr_i            = a;
    data_i            = d;
    memop_data_type_i = t;
    cyc();
    req_store_i = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] t);
    req_load_i        = 1'b1;
    addr_i            = a;
    memop_data_type_i = t;
    settle();
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    // Junk on the inputs while reset is held must not leak into state.
    clear_inputs();
    rst_i = 1'b1; req_store_i = 1'b1; addr_i = 32'h100; data_i = 32'h1234; flush_all_i = 1'b1;
    cyc();
    clear_inputs();
    rst_i = 1'b0; flush_chance_i = 1'b1; drain_ready_i = 1'b1;
    settle();
    tests_run++;
    if ({empty_o, full_o, drain_valid_o, flush_done_o} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL reset_flags: got empty,full,dvalid,done=%b expected 1000",
               {empty_o, full_o, drain_valid_o, flush_done_o});
    end
    tests_run++;
    if ({addr_o, drain_data_o, memop_data_type_o, data_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got addr=%h data=%h type=%0d fwd=%h expected all zero",
               addr_o, drain_data_o, memop_data_type_o, data_o);
    end
    tests_run++;
    if ({hit_o, miss_o, trouble_o} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_lookup_idle: got hit,miss,trouble=%b expected 000", {hit_o, miss_o, trouble_o});
    end
    cyc();
    // Flush pulse with nothing buffered: FLUSH at N+1, done pulse at N+2.
    clear_inputs();
    flush_all_i = 1'b1;
    cyc();
    flush_all_i = 1'b0;
    settle();
    tests_run++;
    if (flush_done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_fence_n1: got done=%b expected 0", flush_done_o);
    end
    cyc();
    settle();
    tests_run++;
    if (flush_done_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL empty_fence_n2: got done=%b expected 1", flush_done_o);
    end
    cyc();
    settle();
    tests_run++;
    if (flush_done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_fence_n3: got done=%b expected 0", flush_done_o);
    end
  endtask

  task automatic test_hit_miss();
    do_reset();
    // Load in the same cycle as the store must not see it.
    req_store_i = 1'b1; req_load_i = 1'b1;
    addr_i = 32'h100; data_i = 32'hDEADBEEF; memop_data_type_i = T_WORD;
    settle();
    tests_run++;
    if ({hit_o, miss_o, trouble_o} !== 3'b010) begin
      tests_failed++;
      $display("FAIL same_cycle_load: got hit,miss,trouble=%b expected 010", {hit_o, miss_o, trouble_o});
    end
    cyc();
    req_store_i = 1'b0;
    load(32'h100, T_WORD);
    tests_run++;
    if ({hit_o, miss_o, trouble_o, data_o} !== {3'b100, 32'hDEADBEEF}) begin
      tests_failed++;
      $display("FAIL word_hit: got hmt=%b data=%h expected 100 deadbeef", {hit_o, miss_o, trouble_o}, data_o);
    end
    load(32'h200, T_WORD);
    tests_run++;
    if ({hit_o, miss_o, trouble_o, data_o} !== {3'b010, 32'h0}) begin
      tests_failed++;
      $display("FAIL word_miss: got hmt=%b data=%h expected 010 00000000", {hit_o, miss_o, trouble_o}, data_o);
    end
    req_load_i = 1'b0;
    cyc();
  endtask

  task automatic test_trouble();
    // Buffer still holds WORD 0x100 from test_hit_miss.
    push(32'h101, 32'h0000AB00, T_BYTE);
    load(32'h100, T_WORD);
    tests_run++;
    if ({hit_o, miss_o, trouble_o, data_o} !== {3'b001, 32'h0}) begin
      tests_failed++;
      $display("FAIL partial_trouble: got hmt=%b data=%h expected 001 00000000", {hit_o, miss_o, trouble_o}, data_o);
    end
    load(32'h101, T_BYTE);
    tests_run++;
    if ({hit_o, miss_o, trouble_o, data_o} !== {3'b100, 32'h0000AB00}) begin
      tests_failed++;
      $display("FAIL byte_hit: got hmt=%b data=%h expected 100 0000ab00", {hit_o, miss_o, trouble_o}, data_o);
    end
    load(32'h102, T_HALF);
    tests_run++;
    if ({hit_o, miss_o, trouble_o} !== 3'b001) begin
      tests_failed++;
      $display("FAIL half_trouble: got hmt=%b expected 001", {hit_o, miss_o, trouble_o});
    end
    req_load_i = 1'b0;
    cyc();
  endtask

  task automatic test_full_wrap();
    logic [31:0] ea, ed;
    do_reset();
    // Offset head/tail by one slot so every round crosses the wrap point.
    push(32'h50, 32'h55, T_WORD);
    flush_chance_i = 1'b1; drain_ready_i = 1'b1;
    cyc();
    flush_chance_i = 1'b0; drain_ready_i = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++)
        push(32'h1000 + 32'(r) * 32'h100 + 32'(i) * 4, 32'hA0000000 | (32'(r) << 8) | 32'(i), T_WORD);
      settle();
      tests_run++;
      if ({full_o, empty_o} !== 2'b10) begin
        tests_failed++;
        $display("FAIL full_r%0d: got full,empty=%b expected 10", r, {full_o, empty_o});
      end
      push(32'h9000, 32'hFFFFFFFF, T_WORD);
      load(32'h9000, T_WORD);
      tests_run++;
      if ({miss_o, full_o} !== 2'b11) begin
        tests_failed++;
        $display("FAIL overflow_ignored_r%0d: got miss,full=%b expected 11", r, {miss_o, full_o});
      end
      req_load_i = 1'b0;
      flush_chance_i = 1'b1; drain_ready_i = 1'b1;
      for (int i = 0; i < N; i++) begin
        ea = 32'h1000 + 32'(r) * 32'h100 + 32'(i) * 4;
        ed = 32'hA0000000 | (32'(r) << 8) | 32'(i);
        settle();
        tests_run++;
        if ({drain_valid_o, addr_o, drain_data_o, memop_data_type_o} !== {1'b1, ea, ed, T_WORD}) begin
          tests_failed++;
          $display("FAIL drain_r%0d_e%0d: got v=%b addr=%h data=%h type=%0d expected 1 %h %h 2",
                   r, i, drain_valid_o, addr_o, drain_data_o, memop_data_type_o, ea, ed);
        end
        cyc();
      end
      settle();
      tests_run++;
      if ({empty_o, drain_valid_o} !== 2'b10) begin
        tests_failed++;
        $display("FAIL drained_r%0d: got empty,dvalid=%b expected 10", r, {empty_o, drain_valid_o});
      end
      flush_chance_i = 1'b0; drain_ready_i = 1'b0;
      cyc();
    end
  endtask

  task automatic test_full_pop();
    int pops;
    do_reset();
    for (int i = 0; i < N; i++) push(32'h2000 + 32'(i) * 4, 32'hB0 + 32'(i), T_WORD);
    // Push while full is dropped even though a pop frees a slot this cycle.
    req_store_i = 1'b1; addr_i = 32'h3000; data_i = 32'hCC; memop_data_type_i = T_WORD;
    flush_chance_i = 1'b1; drain_ready_i = 1'b1;
    settle();
    tests_run++;
    if ({drain_valid_o, addr_o} !== {1'b1, 32'h2000}) begin
      tests_failed++;
      $display("FAIL full_pop_head: got v=%b addr=%h expected 1 00002000", drain_valid_o, addr_o);
    end
    cyc();
    req_store_i = 1'b0;
    pops = 0;
    for (int c = 0; c < 8; c++) begin
      settle();
      if (drain_valid_o) pops++;
      cyc();
    end
    tests_run++;
    if (pops !== N - 1) begin
      tests_failed++;
      $display("FAIL full_pop_dropped: got %0d remaining pops expected %0d", pops, N - 1);
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(32'h300, 32'h11, T_WORD);
    // Simultaneous push and pop: head moves on, new entry stays.
    req_store_i = 1'b1; addr_i = 32'h304; data_i = 32'h22; memop_data_type_i = T_WORD;
    flush_chance_i = 1'b1; drain_ready_i = 1'b1;
    cyc();
    req_store_i = 1'b0;
    settle();
    tests_run++;
    if ({drain_valid_o, addr_o, drain_data_o, full_o} !== {1'b1, 32'h304, 32'h22, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_head: got v=%b addr=%h data=%h full=%b expected 1 00000304 00000022 0",
               drain_valid_o, addr_o, drain_data_o, full_o);
    end
    cyc();
    settle();
    tests_run++;
    if (empty_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_empty: got empty=%b expected 1", empty_o);
    end
    clear_inputs();
  endtask

  task automatic test_coalesce();
    int          pops_c, pops_nc;
    logic [31:0] last_c;
    logic [31:0] first_nc;
    do_reset();
    push(32'h40, 32'h1, T_WORD);
    push(32'h40, 32'h2, T_WORD);
    load(32'h40, T_WORD);
    tests_run++;
    if ({hit_o, data_o} !== {1'b1, 32'h2}) begin
      tests_failed++;
      $display("FAIL coalesce_fwd: got hit=%b data=%h expected 1 00000002", hit_o, data_o);
    end
    req_load_i = 1'b0;
    flush_chance_i = 1'b1; drain_ready_i = 1'b1;
    pops_c = 0; pops_nc = 0; last_c = '0; first_nc = '0;
    for (int c = 0; c < 6; c++) begin
      settle();
      if (drain_valid_o) begin pops_c++; last_c = drain_data_o; end
      if (nc_drain_valid) begin
        if (pops_nc == 0) first_nc = nc_drain_data;
        pops_nc++;
      end
      cyc();
    end
    tests_run++;
    if ({pops_c, last_c} !== {32'd1, 32'h2}) begin
      tests_failed++;
      $display("FAIL coalesce_on: got pops=%0d data=%h expected 1 00000002", pops_c, last_c);
    end
    tests_run++;
    if ({pops_nc, first_nc} !== {32'd2, 32'h1}) begin
      tests_failed++;
      $display("FAIL coalesce_off: got pops=%0d first=%h expected 2 00000001", pops_nc, first_nc);
    end
    // Youngest entry is also the head and is popping: store must push.
    flush_chance_i = 1'b0; drain_ready_i = 1'b0;
    push(32'h60, 32'h5, T_WORD);
    req_store_i = 1'b1; addr_i = 32'h60; data_i = 32'h6; memop_data_type_i = T_WORD;
    flush_chance_i = 1'b1; drain_ready_i = 1'b1;
    settle();
    tests_run++;
    if ({drain_valid_o, drain_data_o} !== {1'b1, 32'h5}) begin
      tests_failed++;
      $display("FAIL nocoal_pop_old: got v=%b data=%h expected 1 00000005", drain_valid_o, drain_data_o);
    end
    cyc();
    req_store_i = 1'b0;
    settle();
    tests_run++;
    if ({drain_valid_o, drain_data_o} !== {1'b1, 32'h6}) begin
      tests_failed++;
      $display("FAIL nocoal_pop_new: got v=%b data=%h expected 1 00000006", drain_valid_o, drain_data_o);
    end
    cyc();
    clear_inputs();
  endtask

  task automatic test_flush();
    int valids, dones;
    do_reset();
    push(32'h700, 32'h71, T_WORD);
    push(32'h704, 32'h72, T_WORD);
    flush_all_i = 1'b1; drain_ready_i = 1'b1;
    settle();
    tests_run++;
    if (drain_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_idle_no_drain: got dvalid=%b expected 0", drain_valid_o);
    end
    cyc();
    flush_all_i = 1'b0;
    valids = 0; dones = 0;
    for (int c = 0; c < 10; c++) begin
      settle();
      if (drain_valid_o) valids++;
      if (flush_done_o) dones++;
      cyc();
    end
    tests_run++;
    if ({valids, dones} !== {32'd2, 32'd1}) begin
      tests_failed++;
      $display("FAIL fence_drain: got valid cycles=%0d done pulses=%0d expected 2 1", valids, dones);
    end
    // Back in IDLE: a new entry is held without flush_chance_i.
    push(32'h708, 32'h73, T_WORD);
    settle();
    tests_run++;
    if ({drain_valid_o, empty_o} !== 2'b00) begin
      tests_failed++;
      $display("FAIL fence_back_idle: got dvalid,empty=%b expected 00", {drain_valid_o, empty_o});
    end
    clear_inputs();
  endtask

  task automatic test_reset_flush();
    int dones;
    do_reset();
    for (int i = 0; i < 3; i++) push(32'h800 + 32'(i) * 4, 32'h80 + 32'(i), T_WORD);
    flush_all_i = 1'b1;
    cyc();
    flush_all_i = 1'b0;
    settle();
    tests_run++;
    if (drain_valid_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_entered: got dvalid=%b expected 1", drain_valid_o);
    end
    cyc();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    drain_ready_i = 1'b1;
    settle();
    tests_run++;
    if ({empty_o, drain_valid_o} !== 2'b10) begin
      tests_failed++;
      $display("FAIL reset_mid_flush: got empty,dvalid=%b expected 10", {empty_o, drain_valid_o});
    end
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      settle();
      if (flush_done_o) dones++;
      cyc();
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL reset_no_done: got %0d done pulses expected 0", dones);
    end
    clear_inputs();
  endtask

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    cyc();
    test_reset();
    test_hit_miss();
    test_trouble();
    test_full_wrap();
    test_full_pop();
    test_back_to_back();
    test_coalesce();
    test_flush();
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
